// File: rtl/mt_thread_sched.sv
// Barrel-processor thread scheduler: round-robin issue over runnable threads, per-thread in-flight
// tracking, and a fixed-depth delay line that turns issued thread IDs into writeback thread IDs.
module mt_thread_sched #(
  parameter int unsigned NUM_THREADS = 8,
  parameter int unsigned PIPE_DEPTH  = 4,
  localparam int unsigned BITS_THREADS = $clog2(NUM_THREADS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_valid,
  input  logic [BITS_THREADS-1:0] start_tid,
  input  logic                    halt_valid,
  input  logic [BITS_THREADS-1:0] halt_tid,
  output logic                    issue_valid,
  output logic [BITS_THREADS-1:0] tid_read,
  output logic                    wb_valid,
  output logic [BITS_THREADS-1:0] tid_write,
  output logic [NUM_THREADS-1:0]  active_mask,
  output logic [NUM_THREADS-1:0]  inflight_mask
);

  logic [BITS_THREADS-1:0] last_tid_q;
  logic [PIPE_DEPTH-1:0]   pipe_v_q;
  logic [BITS_THREADS-1:0] pipe_tid_q [PIPE_DEPTH];

  logic [NUM_THREADS-1:0]  kill_mask;
  logic [NUM_THREADS-1:0]  eligible;
  logic [NUM_THREADS-1:0]  active_d;
  logic [NUM_THREADS-1:0]  inflight_d;
  logic                    sel_found;
  logic [BITS_THREADS-1:0] sel_tid;
  logic [BITS_THREADS-1:0] idx;

  assign wb_valid  = pipe_v_q[PIPE_DEPTH-1];
  assign tid_write = pipe_tid_q[PIPE_DEPTH-1];

  always_comb begin
    // A halt in this cycle must already block the issue decided at this edge, unless the same
    // thread is being restarted (start wins).
    kill_mask = '0;
    if (halt_valid && !(start_valid && (start_tid == halt_tid))) begin
      kill_mask[halt_tid] = 1'b1;
    end
    eligible = active_mask & ~inflight_mask & ~kill_mask;

    sel_found = 1'b0;
    sel_tid   = last_tid_q;
    idx       = last_tid_q;
    for (int i = 1; i <= int'(NUM_THREADS); i++) begin
      idx = last_tid_q + BITS_THREADS'(i);
      if (!sel_found && eligible[idx]) begin
        sel_found = 1'b1;
        sel_tid   = idx;
      end
    end

    active_d = active_mask;
    if (halt_valid) active_d[halt_tid] = 1'b0;
    if (start_valid) active_d[start_tid] = 1'b1;

    // Retiring thread is still marked in flight above, so it never collides with the issue set.
    inflight_d = inflight_mask;
    if (wb_valid) inflight_d[tid_write] = 1'b0;
    if (sel_found) inflight_d[sel_tid] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_mask   <= NUM_THREADS'(1);
      inflight_mask <= '0;
      last_tid_q    <= BITS_THREADS'(NUM_THREADS - 1);
      issue_valid   <= 1'b0;
      tid_read      <= '0;
    end else begin
      active_mask   <= active_d;
      inflight_mask <= inflight_d;
      issue_valid   <= sel_found;
      if (sel_found) begin
        tid_read   <= sel_tid;
        last_tid_q <= sel_tid;
      end
    end
  end

  // Tids only advance with valid entries so the last stage holds its tid across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v_q <= '0;
      for (int i = 0; i < int'(PIPE_DEPTH); i++) pipe_tid_q[i] <= '0;
    end else begin
      pipe_v_q[0] <= issue_valid;
      if (issue_valid) pipe_tid_q[0] <= tid_read;
      for (int i = 1; i < int'(PIPE_DEPTH); i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        if (pipe_v_q[i-1]) pipe_tid_q[i] <= pipe_tid_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_mt_thread_sched.sv
// Directed bench for mt_thread_sched: cycle tables plus hand-written multi-cycle sequences.
module tb_mt_thread_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_valid = 1'b0;
  logic [2:0] start_tid = '0;
  logic       halt_valid = 1'b0;
  logic [2:0] halt_tid = '0;
  logic       issue_valid;
  logic [2:0] tid_read;
  logic       wb_valid;
  logic [2:0] tid_write;
  logic [7:0] active_mask;
  logic [7:0] inflight_mask;

  int checks = 0;
  int errors = 0;

  mt_thread_sched #(.NUM_THREADS(8), .PIPE_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_tid    (start_tid),
    .halt_valid   (halt_valid),
    .halt_tid     (halt_tid),
    .issue_valid  (issue_valid),
    .tid_read     (tid_read),
    .wb_valid     (wb_valid),
    .tid_write    (tid_write),
    .active_mask  (active_mask),
    .inflight_mask(inflight_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sv, st, hv, ht;
    int e_iv, e_tr, e_wv, e_tw, e_act, e_inf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int sv, int st, int hv, int ht, int iv, int tr, int wv, int tw,
                              int act, int inf);
    vec_t v;
    v.sv = sv; v.st = st; v.hv = hv; v.ht = ht;
    v.e_iv = iv; v.e_tr = tr; v.e_wv = wv; v.e_tw = tw; v.e_act = act; v.e_inf = inf;
    return v;
  endfunction

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Asserts reset, releases it on a falling edge; the caller is then in cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    start_valid = 1'b0;
    halt_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_table(string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      chk($sformatf("%s c%0d issue_valid", tag, i), int'(issue_valid), vecs[i].e_iv);
      chk($sformatf("%s c%0d tid_read", tag, i), int'(tid_read), vecs[i].e_tr);
      chk($sformatf("%s c%0d wb_valid", tag, i), int'(wb_valid), vecs[i].e_wv);
      chk($sformatf("%s c%0d tid_write", tag, i), int'(tid_write), vecs[i].e_tw);
      chk($sformatf("%s c%0d active_mask", tag, i), int'(active_mask), vecs[i].e_act);
      chk($sformatf("%s c%0d inflight_mask", tag, i), int'(inflight_mask), vecs[i].e_inf);
      start_valid = vecs[i].sv[0];
      start_tid   = 3'(vecs[i].st);
      halt_valid  = vecs[i].hv[0];
      halt_tid    = 3'(vecs[i].ht);
      @(negedge clk);
    end
    start_valid = 1'b0;
    halt_valid  = 1'b0;
  endtask

  task automatic fill_single_thread();
    vecs.delete();
    //             sv st hv ht iv tr wv tw act    inf
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h01, 'h00));  // c0
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 'h01, 'h01));  // c1
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h01, 'h01));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h01, 'h01));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h01, 'h01));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 'h01, 'h01));  // c5
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h01, 'h00));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 'h01, 'h01));  // c7
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h01, 'h01));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h01, 'h01));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h01, 'h01));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 'h01, 'h01));  // c11
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h01, 'h00));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 'h01, 'h01));  // c13
  endtask

  task automatic fill_two_threads();
    vecs.delete();
    vecs.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 'h01, 'h00));  // c0: start thread 3
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 'h09, 'h01));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 'h09, 'h09));
    vecs.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 'h09, 'h09));
    vecs.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 'h09, 'h09));
    vecs.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0, 'h09, 'h09));  // c5
    vecs.push_back(mk(0, 0, 0, 0, 0, 3, 1, 3, 'h09, 'h08));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 3, 'h09, 'h01));  // c7
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 0, 3, 'h09, 'h09));
    vecs.push_back(mk(0, 0, 0, 0, 0, 3, 0, 3, 'h09, 'h09));
    vecs.push_back(mk(0, 0, 0, 0, 0, 3, 0, 3, 'h09, 'h09));
    vecs.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0, 'h09, 'h09));  // c11
    vecs.push_back(mk(0, 0, 0, 0, 0, 3, 1, 3, 'h09, 'h08));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 3, 'h09, 'h01));  // c13
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 0, 3, 'h09, 'h09));
  endtask

  initial begin
    int n_iss5;
    int n_wb5;

    // Single active thread after reset.
    do_reset();
    fill_single_thread();
    run_table("single");

    // Threads 0 and 3 only.
    do_reset();
    fill_two_threads();
    run_table("pair");

    // Start threads 1..7 one per cycle, then halt thread 5 while it is in flight.
    do_reset();
    n_iss5 = 0;
    n_wb5  = 0;
    for (int c = 0; c <= 40; c++) begin
      if (c >= 1 && c <= 15) begin
        chk($sformatf("full c%0d issue_valid", c), int'(issue_valid), 1);
        chk($sformatf("full c%0d tid_read", c), int'(tid_read), (c - 1) % 8);
      end
      if (c >= 5 && c <= 17) begin
        chk($sformatf("full c%0d wb_valid", c), int'(wb_valid), 1);
        chk($sformatf("full c%0d tid_write", c), int'(tid_write), (c - 5) % 8);
      end
      if (c == 7) chk("full active_mask", int'(active_mask), 'hFF);
      if (c == 16) chk("halt active_mask", int'(active_mask), 'hDF);
      if (c == 18) begin
        chk("halt retire wb_valid", int'(wb_valid), 1);
        chk("halt retire tid_write", int'(tid_write), 5);
      end
      if (c == 22) begin
        chk("halt skip issue_valid", int'(issue_valid), 1);
        chk("halt skip tid_read", int'(tid_read), 6);
      end
      if (c >= 16 && issue_valid && tid_read == 3'd5) n_iss5++;
      if (c >= 16 && wb_valid && tid_write == 3'd5) n_wb5++;
      start_valid = (c <= 6);
      start_tid   = 3'(c + 1);
      halt_valid  = (c == 15);
      halt_tid    = 3'd5;
      @(negedge clk);
    end
    start_valid = 1'b0;
    halt_valid  = 1'b0;
    chk("halted thread reissues", n_iss5, 0);
    chk("halted thread retires", n_wb5, 1);

    // Asynchronous reset with a full pipe, checked before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("async rst issue_valid", int'(issue_valid), 0);
    chk("async rst tid_read", int'(tid_read), 0);
    chk("async rst wb_valid", int'(wb_valid), 0);
    chk("async rst tid_write", int'(tid_write), 0);
    chk("async rst active_mask", int'(active_mask), 'h01);
    chk("async rst inflight_mask", int'(inflight_mask), 'h00);
    do_reset();
    fill_single_thread();
    run_table("restart");

    // Start/halt collisions.
    do_reset();
    chk("sh c0 active_mask", int'(active_mask), 'h01);
    start_valid = 1'b1; start_tid = 3'd2; halt_valid = 1'b1; halt_tid = 3'd2;
    @(negedge clk);
    start_valid = 1'b0; halt_valid = 1'b0;
    chk("sh same-tid inactive", int'(active_mask), 'h05);
    @(negedge clk);
    start_valid = 1'b1; start_tid = 3'd2; halt_valid = 1'b1; halt_tid = 3'd2;
    @(negedge clk);
    chk("sh same-tid active", int'(active_mask), 'h05);
    halt_valid = 1'b0; start_tid = 3'd6;
    @(negedge clk);
    chk("sh start 6", int'(active_mask), 'h45);
    start_tid = 3'd4; halt_valid = 1'b1; halt_tid = 3'd6;
    @(negedge clk);
    start_valid = 1'b0; halt_valid = 1'b0;
    chk("sh start 4 halt 6", int'(active_mask), 'h15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
